// File: rtl/md_ctrl.sv
// Issue and hazard controller for the multiply/divide unit: starts md ops from E,
// tracks their latency, and stalls D-stage md-class instructions while the unit is occupied.
module md_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid_e,
  input  logic [2:0] op_e,
  input  logic       flush_e,
  input  logic       md_use_d,
  output logic       start,
  output logic [2:0] md_op,
  output logic       hilo_we,
  output logic       busy,
  output logic       stall_d,
  output logic       done,
  output logic       err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);
  localparam logic [2:0] OP_IDLE = 3'b111;

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] md_op_q, md_op_d;
  logic       err_q, err_d;

  logic is_idle, is_run, issue, move, is_move_op, last_cycle;

  assign is_idle    = (state_q == IDLE);
  assign is_run     = (state_q == RUN);
  assign is_move_op = (op_e[2:1] == 2'b10);
  assign issue      = is_idle && op_valid_e && !flush_e && !op_e[2];
  assign move       = is_idle && op_valid_e && !flush_e && is_move_op;
  assign last_cycle = is_run && (cnt_q == 4'd1);

  always_comb begin
    start   = issue;
    hilo_we = move;
    busy    = issue || is_run;
    stall_d = busy && md_use_d;
    done    = last_cycle;
    err     = err_q;
    md_op   = OP_IDLE;
    // The held op wins while running, so a stray mthi/mtlo can never reach HI/LO mid-op.
    if (is_run) begin
      md_op = md_op_q;
    end else if (issue || move) begin
      md_op = op_e;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_op_d = md_op_q;
    err_d   = err_q;
    if (issue) begin
      state_d = RUN;
      cnt_d   = op_e[1] ? DIV_CNT : MUL_CNT;
      md_op_d = op_e;
    end else if (is_run) begin
      cnt_d = cnt_q - 4'd1;
      if (last_cycle) begin
        state_d = IDLE;
        md_op_d = OP_IDLE;
      end
    end
    if (is_run && (op_valid_e || (is_move_op && !flush_e))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      md_op_q <= OP_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: the driver queues hand-computed per-cycle expectations,
// and an independent monitor compares them against the DUT outputs on the falling edge.
module tb_md_ctrl;

  typedef struct packed {
    logic       start;
    logic [2:0] md_op;
    logic       hilo_we;
    logic       busy;
    logic       stall_d;
    logic       done;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid_e;
  logic [2:0] op_e;
  logic       flush_e;
  logic       md_use_d;
  logic       start;
  logic [2:0] md_op;
  logic       hilo_we;
  logic       busy;
  logic       stall_d;
  logic       done;
  logic       err;

  exp_t  exp_q[$];
  string tag_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  string cur_tag    = "init";

  md_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op_valid_e(op_valid_e), .op_e(op_e),
    .flush_e(flush_e), .md_use_d(md_use_d), .start(start), .md_op(md_op),
    .hilo_we(hilo_we), .busy(busy), .stall_d(stall_d), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the outputs must be during that cycle.
  task automatic applyStimulus(input logic rst, input logic v, input logic [2:0] op,
                               input logic fl, input logic ud,
                               input logic e_st, input logic [2:0] e_op, input logic e_hw,
                               input logic e_bz, input logic e_sd, input logic e_dn,
                               input logic e_er);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    op_valid_e = v;
    op_e       = op;
    flush_e    = fl;
    md_use_d   = ud;
    e = '{start: e_st, md_op: e_op, hilo_we: e_hw, busy: e_bz, stall_d: e_sd,
          done: e_dn, err: e_er};
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    exp_t a;
    a = '{start: start, md_op: md_op, hilo_we: hilo_we, busy: busy, stall_d: stall_d,
          done: done, err: err};
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("[TB] FAIL %s: got start=%b md_op=%b hilo_we=%b busy=%b stall_d=%b done=%b err=%b, want start=%b md_op=%b hilo_we=%b busy=%b stall_d=%b done=%b err=%b",
               tag, a.start, a.md_op, a.hilo_we, a.busy, a.stall_d, a.done, a.err,
               e.start, e.md_op, e.hilo_we, e.busy, e.stall_d, e.done, e.err);
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checkOutput(e, t);
      end
    end
  end

  initial begin : driver
    reset = 1'b1; op_valid_e = 1'b0; op_e = 3'b111; flush_e = 1'b0; md_use_d = 1'b0;
    @(posedge clk);
    #1;

    cur_tag = "reset";
    applyStimulus(1, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 0);
    cur_tag = "idle";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 0);

    // mult: busy T..T+5, done at T+5
    cur_tag = "mult_issue";
    applyStimulus(0, 1, 3'b000, 0, 0,  1, 3'b000, 0, 1, 0, 0, 0);
    cur_tag = "mult_run";
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b000, 0, 1, 0, 0, 0);
    cur_tag = "mult_done";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b000, 0, 1, 0, 1, 0);
    cur_tag = "mult_after";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 0);

    // divu with a D-stage md op waiting: stall T..T+10
    cur_tag = "divu_issue";
    applyStimulus(0, 1, 3'b011, 0, 1,  1, 3'b011, 0, 1, 1, 0, 0);
    cur_tag = "divu_run";
    for (int i = 1; i <= 9; i++) applyStimulus(0, 0, 3'b111, 0, 1,  0, 3'b011, 0, 1, 1, 0, 0);
    cur_tag = "divu_done";
    applyStimulus(0, 0, 3'b111, 0, 1,  0, 3'b011, 0, 1, 1, 1, 0);
    cur_tag = "divu_release";
    applyStimulus(0, 0, 3'b111, 0, 1,  0, 3'b111, 0, 0, 0, 0, 0);

    // HI/LO moves and reads in IDLE
    cur_tag = "mtlo";
    applyStimulus(0, 1, 3'b101, 0, 0,  0, 3'b101, 1, 0, 0, 0, 0);
    cur_tag = "mthi";
    applyStimulus(0, 1, 3'b100, 0, 0,  0, 3'b100, 1, 0, 0, 0, 0);
    cur_tag = "mfhi";
    applyStimulus(0, 1, 3'b110, 0, 0,  0, 3'b111, 0, 0, 0, 0, 0);
    cur_tag = "move_after";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 0);

    // flushed mult never issues; flushed mthi never writes
    cur_tag = "mult_flushed";
    applyStimulus(0, 1, 3'b000, 1, 0,  0, 3'b111, 0, 0, 0, 0, 0);
    cur_tag = "mthi_flushed";
    applyStimulus(0, 1, 3'b100, 1, 0,  0, 3'b111, 0, 0, 0, 0, 0);
    cur_tag = "flush_after";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 0);

    // div with a flush at T+2: still completes at T+10, no error
    cur_tag = "div_issue";
    applyStimulus(0, 1, 3'b010, 0, 0,  1, 3'b010, 0, 1, 0, 0, 0);
    cur_tag = "div_run";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b010, 0, 1, 0, 0, 0);
    cur_tag = "div_flush";
    applyStimulus(0, 0, 3'b010, 1, 0,  0, 3'b010, 0, 1, 0, 0, 0);
    cur_tag = "div_run";
    for (int i = 3; i <= 9; i++) applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b010, 0, 1, 0, 0, 0);
    cur_tag = "div_done";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b010, 0, 1, 0, 1, 0);
    cur_tag = "div_after";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 0);

    // reset at T+3 of a div aborts it without a done pulse
    cur_tag = "abort_issue";
    applyStimulus(0, 1, 3'b010, 0, 0,  1, 3'b010, 0, 1, 0, 0, 0);
    cur_tag = "abort_run";
    for (int i = 1; i <= 2; i++) applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b010, 0, 1, 0, 0, 0);
    cur_tag = "abort_reset";
    applyStimulus(1, 0, 3'b111, 0, 0,  0, 3'b010, 0, 1, 0, 0, 0);
    cur_tag = "abort_after";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 0);

    // mthi presented during a mult: sticky error, no HI/LO write, op still completes
    cur_tag = "err_issue";
    applyStimulus(0, 1, 3'b000, 0, 0,  1, 3'b000, 0, 1, 0, 0, 0);
    cur_tag = "err_run";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b000, 0, 1, 0, 0, 0);
    cur_tag = "err_trigger";
    applyStimulus(0, 1, 3'b100, 0, 0,  0, 3'b000, 0, 1, 0, 0, 0);
    cur_tag = "err_set";
    for (int i = 3; i <= 4; i++) applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b000, 0, 1, 0, 0, 1);
    cur_tag = "err_done";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b000, 0, 1, 0, 1, 1);
    cur_tag = "err_sticky";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 1);
    cur_tag = "err_reset";
    applyStimulus(1, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 1);
    cur_tag = "err_cleared";
    applyStimulus(0, 0, 3'b111, 0, 0,  0, 3'b111, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
